// File: rtl/fire_ctrl_pkg.sv
// fire_ctrl_pkg
// Shared definitions for the fire-control sequencer: FSM state encoding,
// error codes, the attack-mode selector value and a small index-width helper
// used by both the top level and the round-robin arbiter.
package fire_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_RELOAD   = 2'd3
  } fc_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MODE = 2'b01;
  localparam logic [1:0] ERR_AMMO = 2'b10;

  localparam logic [3:0] ATTACK_MODE = 4'b0010;

  // Width of a station index; kept at least 1 so a single-station build still
  // has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search begins at the station
// after the last winner (ptr + 1 mod NREQ) and wraps around, so the last
// winner has the lowest priority.
// Ports:
//   req     - per-station request vector
//   ptr     - index of the most recently granted station
//   onehot  - one-hot winner (all zero when no request)
//   idx     - binary index of the winner (0 when no request)
//   any     - at least one request is present
module rr_arbiter
  import fire_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [idx_w(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        onehot,
  output logic [idx_w(NREQ)-1:0] idx,
  output logic                   any
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Rotating priority scan: the first requesting station after ptr wins.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s         = IW'((int'(ptr) + i) % NREQ);
      hit_s          = ~found_s & req[cand_s];
      onehot[cand_s] = hit_s;
      idx            = hit_s ? cand_s : idx;
      found_s        = found_s | hit_s;
    end
  end

  assign any = |req;

endmodule

// File: rtl/fire_control.sv
// fire_control
// Fire-control sequencer sharing one magazine among NREQ stations. Arbitrates
// fire requests round-robin, deducts rounds per shot, enforces a cooldown
// after every shot and sequences timed reloads. Fire attempts outside attack
// mode or with insufficient ammo produce a one-cycle error pulse.
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-high reset
//   mode_selector  - ship mode, ATTACK_MODE enables firing
//   req            - per-station level fire requests
//   cost           - rounds consumed per shot
//   reload_req     - reload request (level or pulse)
//   reload_amt     - rounds added per reload
//   grant          - one-hot shot grant, one-cycle pulse
//   ammo           - current magazine count
//   busy           - sequencer not idle
//   reloading      - sequencer in reload
//   error/err_code - one-cycle error pulse with its cause
module fire_control
  import fire_ctrl_pkg::*;
#(
  parameter int W          = 9,
  parameter int NREQ       = 4,
  parameter int COOLDOWN   = 3,
  parameter int RELOAD_CYC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mode_selector,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    cost,
  input  logic            reload_req,
  input  logic [W-1:0]    reload_amt,
  output logic [NREQ-1:0] grant,
  output logic [W-1:0]    ammo,
  output logic            busy,
  output logic            reloading,
  output logic            error,
  output logic [1:0]      err_code
);

  localparam int IW      = idx_w(NREQ);
  localparam int CNT_MAX = (COOLDOWN > RELOAD_CYC) ? COOLDOWN : RELOAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Last count value of each timed phase (cooldown value unused when 0).
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(RELOAD_CYC - 1);

  fc_state_e        state_r,  state_nx_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nx_s;
  logic [W-1:0]     ammo_r,   ammo_nx_s;
  logic [W-1:0]     amt_r,    amt_nx_s;
  logic [IW-1:0]    ptr_r,    ptr_nx_s;
  logic             pend_r,   pend_nx_s;
  logic [NREQ-1:0]  grant_r,  grant_nx_s;
  logic             error_r,  error_nx_s;
  logic [1:0]       code_r,   code_nx_s;
  logic             busy_r;
  logic             reloading_r;

  logic [NREQ-1:0]  win_onehot_s;
  logic [IW-1:0]    win_idx_s;
  logic             any_req_s;
  logic [W:0]       reload_sum_s;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (win_onehot_s),
    .idx    (win_idx_s),
    .any    (any_req_s)
  );

  // One extra bit so the reload sum can be saturated instead of wrapping.
  assign reload_sum_s = {1'b0, ammo_r} + {1'b0, amt_r};

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    ammo_nx_s  = ammo_r;
    amt_nx_s   = amt_r;
    ptr_nx_s   = ptr_r;
    pend_nx_s  = pend_r;
    grant_nx_s = '0;
    error_nx_s = 1'b0;
    code_nx_s  = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (reload_req || pend_r) begin
          // Reload wins over any fire request in the same cycle.
          state_nx_s = ST_RELOAD;
          amt_nx_s   = reload_amt;
          pend_nx_s  = 1'b0;
          cnt_nx_s   = '0;
        end else if (any_req_s && (mode_selector != ATTACK_MODE)) begin
          error_nx_s = 1'b1;
          code_nx_s  = ERR_MODE;
        end else if (any_req_s && (cost != '0) && (ammo_r >= cost)) begin
          state_nx_s = ST_FIRE;
          grant_nx_s = win_onehot_s;
          ptr_nx_s   = win_idx_s;
          ammo_nx_s  = ammo_r - cost;
        end else if (any_req_s) begin
          // Zero cost is treated as an unserviceable shot, same as short ammo.
          error_nx_s = 1'b1;
          code_nx_s  = ERR_AMMO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FIRE: begin
        pend_nx_s = pend_r | reload_req;
        cnt_nx_s  = '0;
        if (COOLDOWN == 0) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        pend_nx_s = pend_r | reload_req;
        if (cnt_r == CD_LAST) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RELOAD: begin
        if (cnt_r == RL_LAST) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
          ammo_nx_s  = reload_sum_s[W] ? {W{1'b1}} : reload_sum_s[W-1:0];
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // State, datapath and output registers; status flags follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      ammo_r      <= '0;
      amt_r       <= '0;
      ptr_r       <= IW'(NREQ - 1);
      pend_r      <= 1'b0;
      grant_r     <= '0;
      error_r     <= 1'b0;
      code_r      <= ERR_NONE;
      busy_r      <= 1'b0;
      reloading_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      ammo_r      <= ammo_nx_s;
      amt_r       <= amt_nx_s;
      ptr_r       <= ptr_nx_s;
      pend_r      <= pend_nx_s;
      grant_r     <= grant_nx_s;
      error_r     <= error_nx_s;
      code_r      <= code_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
      reloading_r <= (state_nx_s == ST_RELOAD);
    end
  end

  assign grant     = grant_r;
  assign ammo      = ammo_r;
  assign busy      = busy_r;
  assign reloading = reloading_r;
  assign error     = error_r;
  assign err_code  = code_r;

endmodule

// File: doc/fire_control.md
# fire_control

Fire-control sequencer that shares one ammunition magazine among `NREQ` weapon stations. It arbitrates fire requests round-robin, deducts rounds per shot, enforces a cooldown between shots and sequences timed reloads. It flags fire attempts outside attack mode or with insufficient ammo. It sits between the station trigger logic and the ammo/weapons datapath, and owns the magazine count.

## Interface
Parameters:
- `W`, 9, ammo count and cost width
- `NREQ`, 4, number of requesting stations
- `COOLDOWN`, 3, cycles in COOLDOWN after each shot (0 legal)
- `RELOAD_CYC`, 8, cycles spent in RELOAD (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `mode_selector`  in  4  ship mode; `4'b0010` = attack
- `req`  in  NREQ  per-station fire request, level
- `cost`  in  W  rounds consumed per shot
- `reload_req`  in  1  request reload, level or pulse
- `reload_amt`  in  W  rounds added per reload
- `grant`  out  NREQ  one-hot shot grant, 1-cycle pulse
- `ammo`  out  W  current magazine count
- `busy`  out  1  state ≠ IDLE
- `reloading`  out  1  state = RELOAD
- `error`  out  1  1-cycle error pulse
- `err_code`  out  2  01 wrong mode, 10 insufficient ammo, 00 otherwise

## Operation
- States: IDLE, FIRE, COOLDOWN, RELOAD. All outputs are registered.
- IDLE, evaluated in priority order:
  - `reload_req` or `pend_reload` → RELOAD. Latch `reload_amt`, clear `pend_reload`, ignore `req` this cycle.
  - `|req` and mode ≠ attack → `error`=1, `err_code`=01, stay IDLE.
  - `|req`, attack, `cost`≠0, `ammo`≥`cost` → FIRE. The round-robin winner's `grant` bit is set and `ammo`←`ammo`−`cost` on the same edge.
  - `|req`, attack, and (`ammo`<`cost` or `cost`=0) → `error`=1, `err_code`=10, no grant, `ammo` unchanged.
- FIRE: one cycle. Goes to COOLDOWN, or directly to IDLE if `COOLDOWN`=0.
- COOLDOWN: counts `COOLDOWN` cycles, then IDLE. `req` is ignored, with no error.
- `reload_req` seen in FIRE or COOLDOWN sets `pend_reload`, which is serviced on return to IDLE.
- RELOAD: counts `RELOAD_CYC` cycles. On the final edge, `ammo`←min(`ammo`+latched amt, 2^W−1), computed at W+1 bits and saturated. Then IDLE. `req` is ignored with no error; `reload_req` is ignored.
- Round-robin: pointer holds the last granted index. Search starts at pointer+1 mod NREQ. The pointer updates only on grant.
- `error` and `err_code` are pulses. They repeat every IDLE cycle while the offending `req` persists. `err_code`=00 whenever `error`=0.

## Timing
- Reset (async): state IDLE, `ammo`=0, `grant`=0, `busy`=0, `reloading`=0, `error`=0, `err_code`=00, pointer=NREQ−1 (station 0 wins first), counters 0, `pend_reload`=0.
- A `req` sampled in IDLE at cycle t gives `grant` and the new `ammo` visible at t+1 for exactly one cycle.
- Shot-to-shot spacing under continuous `req` is `COOLDOWN`+2 cycles (5 at default).
- An error is visible at t+1.
- A reload sampled at t gives `reloading`=1 for cycles t+1..t+`RELOAD_CYC`. The updated `ammo` is visible at t+`RELOAD_CYC`+1, which is also the first cycle back in IDLE.
- `ammo`=`cost` exactly: the shot is granted and `ammo` reaches 0.
- Reset asserted mid-FIRE, mid-COOLDOWN or mid-RELOAD aborts immediately. A pending reload is lost and `ammo` returns to 0.

## Structure
- Package `fire_ctrl_pkg` holds:
  - the state enum
  - `ERR_NONE`/`ERR_MODE`/`ERR_AMMO` codes
  - `ATTACK_MODE` = `4'b0010`
- Sub-module `rr_arbiter` (NREQ param). Inputs: `req`, pointer. Outputs: one-hot winner, winner index, any. Purely combinational.
- The top holds the FSM, ammo register, counters, pointer and output registers.

## Test plan
- Reset, reload 100 (`reload_amt`=100) → `reloading` high 8 cycles, `ammo`=100 at cycle 9. Then `req`=4'b0001, `cost`=3 in attack mode → `grant`=0001 one cycle, `ammo`=97.
- `req`=4'b1111 held, `ammo`=100, `cost`=1 → grants 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart; `ammo` goes 99, 98, 97, 96, 95.
- `mode_selector`=4'b0001, `req`=0001 → `error` pulse each IDLE cycle, `err_code`=01, no grant, `ammo` unchanged.
- `ammo`=2, `cost`=3 → `err_code`=10, no grant. Then `cost`=2 → granted, `ammo`=0.
- `ammo`=500, reload 100 → saturates to 511. `reload_req` pulsed during COOLDOWN → RELOAD entered immediately after COOLDOWN ends.
- `rst` asserted mid-RELOAD → all outputs reset asynchronously, no `ammo` update, `pend_reload` cleared.
